// File: rtl/cfg_lut_k.sv
// cfg_lut_k: K-input LUT with serially loaded truth table and output mode.
// The config chain passes through cfg_din -> cfg_dout, so LUTs can share one stream.
module cfg_lut_k #(
  parameter int unsigned K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_clr,
  input  logic         cfg_en,
  input  logic         cfg_din,
  output logic         cfg_dout,
  output logic         cfg_done,
  input  logic [K-1:0] lut_in,
  input  logic         ce,
  output logic         lut_out
);

  localparam int unsigned MASK_W = 1 << K;
  localparam int unsigned CFG_W  = MASK_W + 1;
  localparam int unsigned CNT_W  = $clog2(CFG_W + 1);

  typedef enum logic [1:0] {
    ST_UNCONFIG   = 2'd0,
    ST_LOADING    = 2'd1,
    ST_CONFIGURED = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CFG_W-1:0]    r_chain;
  logic                r_q;
  logic [MASK_W-1:0]   w_mask;
  logic                w_mode;
  logic                w_lut_bit;
  logic                w_configured;

  assign w_mask       = r_chain[MASK_W-1:0];
  assign w_mode       = r_chain[CFG_W-1];
  assign w_lut_bit    = w_mask[lut_in];
  assign w_configured = (r_state == ST_CONFIGURED);

  // State and bit-counter register; clear has the same effect as reset
  always_ff @(posedge clk) begin
    if (!rst_n || cfg_clr) begin
      r_state <= ST_UNCONFIG;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter logic; counter saturates at CFG_W so daisy-chained bits pass through
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_UNCONFIG, ST_CONFIGURED: begin
        if (cfg_en) begin
          w_state_nxt = ST_LOADING;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_LOADING: begin
        if (cfg_en) begin
          if (r_cnt < CNT_W'(CFG_W)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else if (r_cnt == CNT_W'(CFG_W)) begin
          w_state_nxt = ST_CONFIGURED;
        end
      end
      default: begin
        w_state_nxt = ST_UNCONFIG;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Config shift chain; first bit sent ends in chain[0] after CFG_W shifts
  always_ff @(posedge clk) begin
    if (!rst_n || cfg_clr) begin
      r_chain <= '0;
    end else if (cfg_en) begin
      r_chain <= {cfg_din, r_chain[CFG_W-1:1]};
    end
  end

  // Registered-mode output flop; forced low whenever not configured
  always_ff @(posedge clk) begin
    if (!rst_n || cfg_clr) begin
      r_q <= 1'b0;
    end else if (!w_configured) begin
      r_q <= 1'b0;
    end else if (ce) begin
      r_q <= w_lut_bit;
    end
  end

  assign cfg_dout = r_chain[0];
  assign cfg_done = w_configured;
  // Output is masked while loading so partially shifted contents never appear
  assign lut_out  = w_configured & (w_mode ? r_q : w_lut_bit);

endmodule

// File: tb/tb_cfg_lut_k.sv
// tb_cfg_lut_k: directed test of cfg_lut_k (K=4) including a two-LUT daisy chain.
module tb_cfg_lut_k;

  logic       clk;
  logic       rst_n;
  logic       cfg_clr;
  logic       cfg_en;
  logic       cfg_din;
  logic       ce;
  logic [3:0] lut_in_a;
  logic [3:0] lut_in_b;
  logic       dout_a;
  logic       dout_b;
  logic       done_a;
  logic       done_b;
  logic       out_a;
  logic       out_b;

  int n_checks;
  int n_errors;

  cfg_lut_k #(.K(4)) u_a (
    .clk(clk), .rst_n(rst_n), .cfg_clr(cfg_clr), .cfg_en(cfg_en), .cfg_din(cfg_din),
    .cfg_dout(dout_a), .cfg_done(done_a), .lut_in(lut_in_a), .ce(ce), .lut_out(out_a)
  );

  cfg_lut_k #(.K(4)) u_b (
    .clk(clk), .rst_n(rst_n), .cfg_clr(cfg_clr), .cfg_en(cfg_en), .cfg_din(dout_a),
    .cfg_dout(dout_b), .cfg_done(done_b), .lut_in(lut_in_b), .ce(ce), .lut_out(out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Shift n bits of v, LSB first; cfg_en is left high for the caller to drop
  task automatic shift_bits(input logic [33:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_en  = 1'b1;
      cfg_din = v[i];
      @(negedge clk);
    end
  endtask

  task automatic load(input logic [15:0] mask, input logic mode);
    shift_bits({17'd0, mode, mask}, 17);
    chk("load_done_low_while_loading", done_a, 1'b0);
    cfg_en  = 1'b0;
    cfg_din = 1'b0;
    @(negedge clk);
  endtask

  logic [33:0] v;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    cfg_clr  = 1'b0;
    cfg_en   = 1'b0;
    cfg_din  = 1'b0;
    ce       = 1'b0;
    lut_in_a = 4'h0;
    lut_in_b = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_done", done_a, 1'b0);
    chk("rst_out", out_a, 1'b0);
    chk("rst_dout", dout_a, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. AND4, combinational
    load(16'h8000, 1'b0);
    chk("and4_done", done_a, 1'b1);
    lut_in_a = 4'hF; #1;
    chk("and4_F", out_a, 1'b1);
    lut_in_a = 4'hE; #1;
    chk("and4_E", out_a, 1'b0);
    chk("and4_dout", dout_a, 1'b0);

    // 2. Registered XOR4
    load(16'h6996, 1'b1);
    chk("xor_done", done_a, 1'b1);
    ce = 1'b1;
    lut_in_a = 4'h1; #1;
    chk("xor_latency", out_a, 1'b0);
    @(negedge clk);
    chk("xor_1", out_a, 1'b1);
    lut_in_a = 4'h3;
    @(negedge clk);
    chk("xor_3", out_a, 1'b0);
    ce = 1'b0;
    lut_in_a = 4'h1;
    @(negedge clk);
    chk("xor_hold0", out_a, 1'b0);
    @(negedge clk);
    chk("xor_hold1", out_a, 1'b0);
    ce = 1'b1;
    lut_in_a = 4'h7;
    @(negedge clk);
    chk("xor_7", out_a, 1'b1);

    // 3. Partial load, reconfiguring from CONFIGURED
    v = {17'd0, 1'b0, 16'h00FF};
    shift_bits(v, 1);
    chk("reconf_done_drop", done_a, 1'b0);
    chk("reconf_out_drop", out_a, 1'b0);
    shift_bits(v >> 1, 9);
    cfg_en = 1'b0;
    @(negedge clk);
    chk("part_done", done_a, 1'b0);
    lut_in_a = 4'h3; #1;
    chk("part_out", out_a, 1'b0);
    @(negedge clk);
    chk("part_done_hold", done_a, 1'b0);
    shift_bits(v >> 10, 7);
    cfg_en = 1'b0;
    @(negedge clk);
    chk("part_done_full", done_a, 1'b1);
    lut_in_a = 4'h3; #1;
    chk("part_3", out_a, 1'b1);
    lut_in_a = 4'h8; #1;
    chk("part_8", out_a, 1'b0);

    // 4. Daisy chain: far LUT (u_b) bits first
    v = {1'b0, 16'hA5C3, 1'b0, 16'h0F0F};
    shift_bits(v, 20);
    chk("daisy_dout_mid", dout_a, v[3]);
    shift_bits(v >> 20, 14);
    cfg_en = 1'b0;
    @(negedge clk);
    chk("daisy_done_a", done_a, 1'b1);
    chk("daisy_done_b", done_b, 1'b1);
    chk("daisy_dout_a", dout_a, 1'b1);
    chk("daisy_dout_b", dout_b, 1'b1);
    lut_in_a = 4'h0;
    lut_in_b = 4'h4; #1;
    chk("daisy_a0", out_a, 1'b1);
    chk("daisy_b4", out_b, 1'b0);
    lut_in_a = 4'h2;
    lut_in_b = 4'h1; #1;
    chk("daisy_a2", out_a, 1'b0);
    chk("daisy_b1", out_b, 1'b1);

    // 5. Reset mid-load
    shift_bits({17'd0, 17'h1FFFF}, 8);
    cfg_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    chk("midrst_done", done_a, 1'b0);
    chk("midrst_dout", dout_a, 1'b0);
    chk("midrst_out", out_a, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    load(16'h0001, 1'b0);
    chk("fresh_done", done_a, 1'b1);
    lut_in_a = 4'h0; #1;
    chk("fresh_0", out_a, 1'b1);
    lut_in_a = 4'h1; #1;
    chk("fresh_1", out_a, 1'b0);

    // 6. Clear beats simultaneous shift while configured
    lut_in_a = 4'h0;
    cfg_clr  = 1'b1;
    cfg_en   = 1'b1;
    cfg_din  = 1'b1;
    @(negedge clk);
    chk("clr_done", done_a, 1'b0);
    chk("clr_out", out_a, 1'b0);
    chk("clr_dout", dout_a, 1'b0);
    cfg_clr = 1'b0;
    cfg_en  = 1'b0;
    cfg_din = 1'b0;
    @(negedge clk);
    chk("clr_stay_unconfig", done_a, 1'b0);
    chk("clr_chain_zero", dout_a, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
